// File: rtl/ahbl_slave_mem_pkg.sv
// Shared AHB-Lite encodings, FSM state type and byte-lane helpers for the
// word-organised AHB-Lite slave memory.
package ahbl_slave_mem_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_t;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // Sizes above a word are never legal; narrower sizes must be naturally aligned.
    function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            HSIZE_BYTE: ok = 1'b1;
            HSIZE_HALF: ok = ~addr_lo[0];
            HSIZE_WORD: ok = (addr_lo == 2'b00);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            HSIZE_BYTE: mask = 4'b0001 << addr_lo;
            HSIZE_HALF: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:    mask = 4'b1111;
        endcase
        return mask;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  mask);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/ahbl_slave_mem_if.sv
// AHB-Lite slave port bundle; HCLK/HRESETn are kept outside as plain ports.
interface ahbl_slave_mem_if #(
    parameter int AHB_AWIDTH = 32,
    parameter int AHB_DWIDTH = 32
);
    logic                  HSEL;
    logic [AHB_AWIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [1:0]            HTRANS;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic                  HMASTLOCK;
    logic                  HREADY;
    logic [AHB_DWIDTH-1:0] HWDATA;
    logic                  HREADYOUT;
    logic [1:0]            HRESP;
    logic [AHB_DWIDTH-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HMASTLOCK, HWDATA,
        input  HREADY, HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HBURST, HMASTLOCK, HREADY, HWDATA,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahbl_slave_mem_sram.sv
// Word-organised single-write/single-read SRAM with per-byte write enables and a
// registered read port; contents are never reset.
module ahbl_slave_mem_sram #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data only moves on an enabled read, so it stays stable through wait states.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/ahbl_slave_mem.sv
// AHB-Lite slave memory: address decode, wait-state/error FSM, data-phase register
// and write-to-read forwarding in front of a byte-enabled SRAM.
module ahbl_slave_mem
    import ahbl_slave_mem_pkg::*;
#(
    parameter int                    AHB_AWIDTH  = 32,
    parameter int                    AHB_DWIDTH  = 32,
    parameter int                    MEM_DEPTH   = 1024,
    parameter logic [AHB_AWIDTH-1:0] BASE_ADDR   = 32'h1111_A000,
    parameter int                    WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahbl_slave_mem_if.slave   bus
);
    localparam int         IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [3:0] WS       = 4'(WAIT_STATES);
    localparam logic       HAS_WAIT = (WAIT_STATES != 0);

    state_t           state, state_nxt;
    logic [3:0]       wait_cnt, wait_cnt_nxt;
    logic             accept, addr_legal, rd_accept;
    logic [IDX_W-1:0] addr_idx;
    logic [3:0]       addr_mask;
    logic             hready_int, dp_complete, wr_commit;
    logic             dp_valid, dp_write;
    logic [IDX_W-1:0] dp_idx;
    logic [3:0]       dp_mask;
    logic             fwd_hit;
    logic [3:0]       fwd_mask;
    logic [31:0]      fwd_data;
    logic [31:0]      sram_q, rd_word;
    logic             unused_ok;

    assign unused_ok = ^{bus.HBURST, bus.HMASTLOCK, bus.HTRANS[0]};

    always_comb begin
        accept     = bus.HSEL & bus.HREADY & bus.HTRANS[1];
        addr_idx   = bus.HADDR[IDX_W+1:2];
        addr_mask  = lane_mask(bus.HSIZE, bus.HADDR[1:0]);
        addr_legal = size_aligned(bus.HSIZE, bus.HADDR[1:0]) &&
                     (bus.HADDR[AHB_AWIDTH-1:IDX_W+2] == BASE_ADDR[AHB_AWIDTH-1:IDX_W+2]);
        rd_accept  = accept & addr_legal & ~bus.HWRITE;
    end

    assign hready_int  = (state == ST_IDLE) || (state == ST_ERR2);
    assign dp_complete = dp_valid & hready_int;
    assign wr_commit   = dp_complete & dp_write;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // ERR2 behaves like IDLE for a new address phase, giving the two-cycle ERROR response.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_IDLE, ST_ERR2: begin
                state_nxt = ST_IDLE;
                if (accept) begin
                    if (!addr_legal) begin
                        state_nxt = ST_ERR1;
                    end else if (HAS_WAIT) begin
                        state_nxt    = ST_WAIT;
                        wait_cnt_nxt = WS;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                end
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A read accepted on the edge a same-word write commits would see stale SRAM data,
    // so the write lanes are captured here and merged on the way out.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_idx   <= '0;
            dp_mask  <= '0;
            fwd_hit  <= 1'b0;
            fwd_mask <= '0;
            fwd_data <= '0;
        end else begin
            if (accept) begin
                dp_valid <= addr_legal;
                dp_write <= bus.HWRITE;
                dp_idx   <= addr_idx;
                dp_mask  <= addr_mask;
            end else if (dp_complete) begin
                dp_valid <= 1'b0;
            end
            if (rd_accept) begin
                fwd_hit  <= wr_commit && (dp_idx == addr_idx);
                fwd_mask <= dp_mask;
                fwd_data <= bus.HWDATA;
            end
        end
    end

    ahbl_slave_mem_sram #(
        .DEPTH (MEM_DEPTH),
        .IDX_W (IDX_W)
    ) u_sram (
        .clk   (HCLK),
        .we    (wr_commit),
        .be    (dp_mask),
        .waddr (dp_idx),
        .wdata (bus.HWDATA),
        .re    (rd_accept),
        .raddr (addr_idx),
        .rdata (sram_q)
    );

    assign rd_word       = fwd_hit ? merge_lanes(sram_q, fwd_data, fwd_mask) : sram_q;
    assign bus.HREADYOUT = hready_int;
    assign bus.HRESP     = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign bus.HRDATA    = (dp_valid && !dp_write) ? rd_word : '0;
endmodule

// File: tb/tb_ahbl_slave_mem.sv
// Directed bench for ahbl_slave_mem: three instances (0, 2 and 3 wait states) share one
// stimulus bus, and the selected instance is the one addressed and observed.
module tb_ahbl_slave_mem;
    import ahbl_slave_mem_pkg::*;

    localparam int WS_TAB [3] = '{0, 2, 3};
    localparam logic [31:0] ERR_ADDR [4] = '{32'h2000_0000, 32'h1111_AA21, 32'h1111_AA22, 32'h1111_AA20};
    localparam logic        ERR_WR   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic [2:0]  ERR_SIZE [4] = '{3'b010, 3'b001, 3'b010, 3'b011};

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [1:0]  dsel;
    int          total = 0;
    int          bad = 0;

    logic        rdy_v   [3];
    logic [1:0]  resp_v  [3];
    logic [31:0] rdata_v [3];
    logic        rdy;
    logic [1:0]  resp;
    logic [31:0] rdata;

    always #5 HCLK = ~HCLK;

    ahbl_slave_mem_if #(.AHB_AWIDTH(32), .AHB_DWIDTH(32)) bus_if [3] ();

    for (genvar k = 0; k < 3; k++) begin : gen_dut
        assign bus_if[k].HSEL      = hsel && (dsel == 2'(k));
        assign bus_if[k].HADDR     = haddr;
        assign bus_if[k].HWRITE    = hwrite;
        assign bus_if[k].HTRANS    = htrans;
        assign bus_if[k].HSIZE     = hsize;
        assign bus_if[k].HBURST    = hburst;
        assign bus_if[k].HMASTLOCK = 1'b0;
        assign bus_if[k].HWDATA    = hwdata;
        assign bus_if[k].HREADY    = bus_if[k].HREADYOUT;
        assign rdy_v[k]            = bus_if[k].HREADYOUT;
        assign resp_v[k]           = bus_if[k].HRESP;
        assign rdata_v[k]          = bus_if[k].HRDATA;

        ahbl_slave_mem #(
            .AHB_AWIDTH  (32),
            .AHB_DWIDTH  (32),
            .MEM_DEPTH   (1024),
            .BASE_ADDR   (32'h1111_A000),
            .WAIT_STATES (WS_TAB[k])
        ) dut (
            .HCLK    (HCLK),
            .HRESETn (HRESETn),
            .bus     (bus_if[k])
        );
    end

    assign rdy   = rdy_v[dsel];
    assign resp  = resp_v[dsel];
    assign rdata = rdata_v[dsel];

    task automatic set_addr(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [1:0] t);
        hsel   = 1'b1;
        haddr  = a;
        hwrite = w;
        hsize  = s;
        htrans = t;
    endtask

    task automatic set_idle();
        hsel   = 1'b0;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = HSIZE_WORD;
        htrans = HTRANS_IDLE;
    endtask

    // Waits out HREADYOUT-low cycles, samples the completing data phase, then crosses its edge.
    task automatic step(output int waits, output logic [31:0] rd, output logic [1:0] rs);
        waits = 0;
        while (rdy !== 1'b1 && waits < 40) begin
            waits++;
            @(posedge HCLK); #1;
        end
        if (waits >= 40) begin
            total++; bad++;
            $display("[TB] FAIL step_timeout hreadyout=%b required=1", rdy);
        end
        rd = rdata;
        rs = resp;
        @(posedge HCLK); #1;
    endtask

    task automatic select_dut(input logic [1:0] d);
        set_idle();
        dsel = d;
        @(posedge HCLK); #1;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        set_idle();
        dsel   = 2'd0;
        hburst = 3'b000;
        hwdata = 32'h0;
        repeat (2) @(posedge HCLK);
        #1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (rdy_v[k] !== 1'b1) begin
                bad++; $display("[TB] FAIL reset_hreadyout[%0d] got=%b exp=1", k, rdy_v[k]);
            end
            total++;
            if (resp_v[k] !== 2'b00) begin
                bad++; $display("[TB] FAIL reset_hresp[%0d] got=%b exp=00", k, resp_v[k]);
            end
            total++;
            if (rdata_v[k] !== 32'h0) begin
                bad++; $display("[TB] FAIL reset_hrdata[%0d] got=%h exp=0", k, rdata_v[k]);
            end
        end
        #3 HRESETn = 1'b1;
        @(posedge HCLK); #1;
    endtask

    task automatic test_word_rw();
        int w0, w1, w2;
        logic [31:0] rd;
        logic [1:0]  rs;
        select_dut(2'd0);
        set_addr(32'h1111_AA20, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step(w0, rd, rs);
        hwdata = 32'h1234_5678;
        set_addr(32'h1111_AA20, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        step(w1, rd, rs);
        total++;
        if (w0 !== 0 || w1 !== 0) begin
            bad++; $display("[TB] FAIL word_write_waits got=%0d/%0d exp=0/0", w0, w1);
        end
        total++;
        if (rs !== 2'b00) begin
            bad++; $display("[TB] FAIL word_write_resp got=%b exp=00", rs);
        end
        set_idle();
        step(w2, rd, rs);
        total++;
        if (w2 !== 0) begin
            bad++; $display("[TB] FAIL word_read_waits got=%0d exp=0", w2);
        end
        total++;
        if (rd !== 32'h1234_5678) begin
            bad++; $display("[TB] FAIL word_read_data got=%h exp=12345678", rd);
        end
        total++;
        if (rs !== 2'b00) begin
            bad++; $display("[TB] FAIL word_read_resp got=%b exp=00", rs);
        end
    endtask

    task automatic test_byte_half();
        int w;
        logic [31:0] rd;
        logic [1:0]  rs;
        select_dut(2'd0);
        set_addr(32'h1111_AA21, 1'b1, HSIZE_BYTE, HTRANS_NONSEQ);
        step(w, rd, rs);
        hwdata = 32'h0000_AB00;
        set_idle();
        step(w, rd, rs);
        set_addr(32'h1111_AA20, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        step(w, rd, rs);
        set_idle();
        step(w, rd, rs);
        total++;
        if (rd !== 32'h1234_AB78) begin
            bad++; $display("[TB] FAIL byte_write_merge got=%h exp=1234ab78", rd);
        end
        set_addr(32'h1111_AA22, 1'b1, HSIZE_HALF, HTRANS_NONSEQ);
        step(w, rd, rs);
        hwdata = 32'hBEEF_0000;
        set_addr(32'h1111_AA20, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        step(w, rd, rs);
        set_idle();
        step(w, rd, rs);
        total++;
        if (rd !== 32'hBEEF_AB78) begin
            bad++; $display("[TB] FAIL half_write_fwd got=%h exp=beefab78", rd);
        end
        total++;
        if (rs !== 2'b00) begin
            bad++; $display("[TB] FAIL half_read_resp got=%b exp=00", rs);
        end
    endtask

    task automatic test_wait_burst();
        int w;
        logic [31:0] rd;
        logic [1:0]  rs;
        select_dut(2'd1);
        hburst = 3'b011;
        set_addr(32'h1111_AA20, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step(w, rd, rs);
        for (int i = 0; i < 4; i++) begin
            hwdata = 32'hA5A5_0010 + 32'(i);
            if (i < 3) begin
                set_addr(32'h1111_AA24 + 32'(4 * i), 1'b1, HSIZE_WORD, HTRANS_SEQ);
            end else begin
                hburst = 3'b000;
                set_addr(32'h1111_AA2C, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
            end
            step(w, rd, rs);
            total++;
            if (w !== 2 || rs !== 2'b00) begin
                bad++; $display("[TB] FAIL ws2_write_beat%0d waits=%0d resp=%b exp waits=2 resp=00", i, w, rs);
            end
        end
        set_idle();
        step(w, rd, rs);
        total++;
        if (w !== 2) begin
            bad++; $display("[TB] FAIL ws2_read_waits got=%0d exp=2", w);
        end
        total++;
        if (rd !== 32'hA5A5_0013) begin
            bad++; $display("[TB] FAIL ws2_read_fwd got=%h exp=a5a50013", rd);
        end
    endtask

    task automatic test_error();
        int w;
        logic [31:0] rd;
        logic [1:0]  rs;
        select_dut(2'd0);
        for (int i = 0; i < 4; i++) begin
            set_addr(ERR_ADDR[i], ERR_WR[i], ERR_SIZE[i], HTRANS_NONSEQ);
            step(w, rd, rs);
            set_idle();
            hwdata = 32'hFFFF_FFFF;
            total++;
            if (rdy !== 1'b0 || resp !== 2'b01) begin
                bad++; $display("[TB] FAIL err%0d_first rdy=%b resp=%b exp rdy=0 resp=01", i, rdy, resp);
            end
            @(posedge HCLK); #1;
            total++;
            if (rdy !== 1'b1 || resp !== 2'b01 || rdata !== 32'h0) begin
                bad++; $display("[TB] FAIL err%0d_second rdy=%b resp=%b rdata=%h exp rdy=1 resp=01 rdata=0", i, rdy, resp, rdata);
            end
            @(posedge HCLK); #1;
            total++;
            if (rdy !== 1'b1 || resp !== 2'b00) begin
                bad++; $display("[TB] FAIL err%0d_recover rdy=%b resp=%b exp rdy=1 resp=00", i, rdy, resp);
            end
        end
        set_addr(32'h1111_AA20, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        step(w, rd, rs);
        set_idle();
        step(w, rd, rs);
        total++;
        if (rd !== 32'hBEEF_AB78 || rs !== 2'b00) begin
            bad++; $display("[TB] FAIL err_mem_unchanged rdata=%h resp=%b exp rdata=beefab78 resp=00", rd, rs);
        end
    endtask

    task automatic test_busy_burst();
        int w;
        logic [31:0] rd;
        logic [1:0]  rs;
        select_dut(2'd0);
        hburst = 3'b001;
        set_addr(32'h1111_AA40, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step(w, rd, rs);
        hwdata = 32'hC0DE_0040;
        set_addr(32'h1111_AA44, 1'b1, HSIZE_WORD, HTRANS_SEQ);
        step(w, rd, rs);
        hwdata = 32'hC0DE_0044;
        set_addr(32'h1111_AA48, 1'b1, HSIZE_WORD, HTRANS_BUSY);
        step(w, rd, rs);
        hwdata = 32'hDEAD_DEAD;
        set_addr(32'h1111_AA48, 1'b1, HSIZE_WORD, HTRANS_SEQ);
        step(w, rd, rs);
        total++;
        if (w !== 0 || rs !== 2'b00) begin
            bad++; $display("[TB] FAIL busy_cycle waits=%0d resp=%b exp waits=0 resp=00", w, rs);
        end
        hwdata = 32'hC0DE_0048;
        set_idle();
        hburst = 3'b000;
        step(w, rd, rs);
        set_addr(32'h1111_AA40, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        step(w, rd, rs);
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                set_addr(32'h1111_AA44 + 32'(4 * i), 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
            end else begin
                set_idle();
            end
            step(w, rd, rs);
            total++;
            if (rd !== 32'hC0DE_0040 + 32'(4 * i) || w !== 0) begin
                bad++; $display("[TB] FAIL busy_beat%0d rdata=%h waits=%0d exp rdata=%h waits=0", i, rd, w, 32'hC0DE_0040 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int w;
        logic [31:0] rd;
        logic [1:0]  rs;
        select_dut(2'd2);
        set_addr(32'h1111_AA30, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step(w, rd, rs);
        hwdata = 32'hCAFE_F00D;
        set_idle();
        step(w, rd, rs);
        total++;
        if (w !== 3) begin
            bad++; $display("[TB] FAIL ws3_write_waits got=%0d exp=3", w);
        end
        set_addr(32'h1111_AA30, 1'b1, HSIZE_WORD, HTRANS_NONSEQ);
        step(w, rd, rs);
        hwdata = 32'h0BAD_BEEF;
        set_idle();
        @(posedge HCLK); #1;
        total++;
        if (rdy !== 1'b0) begin
            bad++; $display("[TB] FAIL ws3_midwait_rdy got=%b exp=0", rdy);
        end
        #2 HRESETn = 1'b0;
        #1;
        total++;
        if (rdy !== 1'b1 || resp !== 2'b00) begin
            bad++; $display("[TB] FAIL async_reset rdy=%b resp=%b exp rdy=1 resp=00", rdy, resp);
        end
        @(posedge HCLK);
        #3 HRESETn = 1'b1;
        @(posedge HCLK); #1;
        set_addr(32'h1111_AA30, 1'b0, HSIZE_WORD, HTRANS_NONSEQ);
        step(w, rd, rs);
        set_idle();
        step(w, rd, rs);
        total++;
        if (rd !== 32'hCAFE_F00D || w !== 3) begin
            bad++; $display("[TB] FAIL reset_no_write rdata=%h waits=%0d exp rdata=cafef00d waits=3", rd, w);
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_half();
        test_wait_burst();
        test_error();
        test_busy_burst();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end
endmodule
